sqrt_host: RTL and testbench

SQRT_HOST -- requirements
Module: sqrt_host

---
 rtl/sqrt_host.sv | 147 ++++++++++++++
 tb/tb_sqrt_host.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sqrt_host.sv
// Host-side sequencer for an external fp16 square-root unit sharing a bidirectional data bus.
// Drives the operand, waits for RESULT (bounded by TIMEOUT) and returns the captured result and flags.
module sqrt_host #(
    parameter int TIMEOUT        = 64,
    parameter int RECOVER_CYCLES = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic [15:0] i_req_data,
    output logic        o_rsp_valid,
    input  logic        i_rsp_ready,
    output logic [15:0] o_rsp_data,
    output logic        o_rsp_is_nan,
    output logic        o_rsp_is_pinf,
    output logic        o_rsp_is_ninf,
    output logic        o_rsp_timeout,
    inout  wire  [15:0] io_data,
    output logic        o_enable,
    input  logic        i_result,
    input  logic        i_is_nan,
    input  logic        i_is_pinf,
    input  logic        i_is_ninf
);

    // state   | meaning
    // IDLE    | ready for a request
    // DRIVE   | operand on io_data, unit enabled
    // RELEASE | bus turnaround, unit enabled
    // WAIT    | unit computing, counting toward TIMEOUT
    // RESP    | response held until consumer takes it
    // RECOVER | unit held disabled before next transaction
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_DRIVE   = 3'd1;
    localparam logic [2:0] S_RELEASE = 3'd2;
    localparam logic [2:0] S_WAIT    = 3'd3;
    localparam logic [2:0] S_RESP    = 3'd4;
    localparam logic [2:0] S_RECOVER = 3'd5;

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int LW = (RECOVER_CYCLES > 0) ? $clog2(RECOVER_CYCLES + 1) : 1;
    localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

    logic [2:0]    r_state;
    logic          r_cold;
    logic [15:0]   r_operand;
    logic [CW-1:0] r_wait_cnt;
    logic [LW-1:0] r_low_cnt;
    logic [15:0]   r_rsp_data;
    logic          r_rsp_is_nan;
    logic          r_rsp_is_pinf;
    logic          r_rsp_is_ninf;
    logic          r_rsp_timeout;

    logic w_low_sat;
    logic w_low_done;

    // Enable-low cycles are counted from RESP entry so that RESP time counts toward recovery.
    assign w_low_sat  = (int'(r_low_cnt) >= RECOVER_CYCLES);
    assign w_low_done = (int'(r_low_cnt) + 1 >= RECOVER_CYCLES);

    // All handshake and bus controls decode directly from state so reset takes effect without a clock.
    assign o_req_ready = (r_state == S_IDLE);
    assign o_rsp_valid = (r_state == S_RESP);
    assign o_enable    = (r_state == S_DRIVE) || (r_state == S_RELEASE) || (r_state == S_WAIT);
    assign io_data     = (r_state == S_DRIVE) ? r_operand : 16'bz;

    assign o_rsp_data    = r_rsp_data;
    assign o_rsp_is_nan  = r_rsp_is_nan;
    assign o_rsp_is_pinf = r_rsp_is_pinf;
    assign o_rsp_is_ninf = r_rsp_is_ninf;
    assign o_rsp_timeout = r_rsp_timeout;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state       <= S_IDLE;
            r_cold        <= 1'b1;
            r_operand     <= '0;
            r_wait_cnt    <= '0;
            r_low_cnt     <= '0;
            r_rsp_data    <= '0;
            r_rsp_is_nan  <= 1'b0;
            r_rsp_is_pinf <= 1'b0;
            r_rsp_is_ninf <= 1'b0;
            r_rsp_timeout <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_req_valid) begin
                        r_operand <= i_req_data;
                        if (r_cold) begin
                            r_low_cnt <= '0;
                            r_state   <= S_RECOVER;
                        end else begin
                            r_state <= S_DRIVE;
                        end
                    end
                end
                S_DRIVE: r_state <= S_RELEASE;
                S_RELEASE: begin
                    r_wait_cnt <= '0;
                    r_state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (i_result) begin
                        r_rsp_data    <= io_data;
                        r_rsp_is_nan  <= i_is_nan;
                        r_rsp_is_pinf <= i_is_pinf;
                        r_rsp_is_ninf <= i_is_ninf;
                        r_rsp_timeout <= 1'b0;
                        r_low_cnt     <= '0;
                        r_state       <= S_RESP;
                    end else if (r_wait_cnt == WAIT_LAST) begin
                        r_rsp_data    <= 16'hFE00;
                        r_rsp_is_nan  <= 1'b0;
                        r_rsp_is_pinf <= 1'b0;
                        r_rsp_is_ninf <= 1'b0;
                        r_rsp_timeout <= 1'b1;
                        r_low_cnt     <= '0;
                        r_state       <= S_RESP;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    if (!w_low_sat) r_low_cnt <= r_low_cnt + 1'b1;
                    if (i_rsp_ready) r_state <= S_RECOVER;
                end
                S_RECOVER: begin
                    if (!w_low_sat) r_low_cnt <= r_low_cnt + 1'b1;
                    if (w_low_done) begin
                        // First request after reset was parked here and proceeds straight to DRIVE.
                        if (r_cold) begin
                            r_cold  <= 1'b0;
                            r_state <= S_DRIVE;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sqrt_host.sv
// Randomized bench for sqrt_host: a behavioural responder model of the sqrt unit plus a per-cycle
// checker comparing responses, latency, bus ownership and recovery spacing against expectations.
module tb_sqrt_host;

    localparam int TO = 64;
    localparam int RC = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic [15:0] req_data;
    logic        rsp_ready;
    logic        result, is_nan, is_pinf, is_ninf;
    wire         req_ready, rsp_valid, enable;
    wire  [15:0] rsp_data;
    wire         f_nan, f_pinf, f_ninf, f_to;
    wire  [15:0] io_bus;
    logic        drv_en;
    logic [15:0] drv_val;

    assign io_bus = drv_en ? drv_val : 16'bz;

    sqrt_host #(.TIMEOUT(TO), .RECOVER_CYCLES(RC)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_data(req_data),
        .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_data(rsp_data),
        .o_rsp_is_nan(f_nan), .o_rsp_is_pinf(f_pinf), .o_rsp_is_ninf(f_ninf),
        .o_rsp_timeout(f_to), .io_data(io_bus), .o_enable(enable),
        .i_result(result), .i_is_nan(is_nan), .i_is_pinf(is_pinf), .i_is_ninf(is_ninf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] op;
        int          n;      // result appears in WAIT cycle n; 0 or >TO means never
        logic [15:0] res;
        logic [2:0]  fl;     // {nan, pinf, ninf}
    } txn_t;

    typedef struct {
        logic [15:0] data;
        logic [3:0]  fl;     // {nan, pinf, ninf, timeout}
        int          lat;
    } exp_t;

    txn_t txq[$];
    exp_t expq[$];
    int   accq[$];
    txn_t cur;
    int   en_k;
    int   cyc;
    int   n_tests;
    int   n_fail;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic exp_t model(input txn_t t, input bit cold);
        exp_t e;
        if (t.n >= 1 && t.n <= TO) begin
            e.data = t.res;
            e.fl   = {t.fl, 1'b0};
            e.lat  = 3 + t.n;
        end else begin
            e.data = 16'hFE00;
            e.fl   = 4'b0001;
            e.lat  = 3 + TO;
        end
        if (cold) e.lat += RC;
        return e;
    endfunction

    // Responder: samples the operand while enabled, returns a result in the chosen WAIT cycle and
    // drives filler on the bus during earlier WAIT cycles (exposes any host drive contention).
    initial begin
        en_k = 0; drv_en = 1'b0; drv_val = '0;
        result = 1'b0; is_nan = 1'b0; is_pinf = 1'b0; is_ninf = 1'b0;
        cur = '{op: 16'h0, n: 0, res: 16'h0, fl: 3'b0};
        forever begin
            @(posedge clk); #2;
            if (rst || !enable) begin
                en_k = 0; drv_en = 1'b0; result = 1'b0;
            end else begin
                en_k++;
                if (en_k == 1 && txq.size() > 0) cur = txq.pop_front();
                if (en_k >= 3) begin
                    drv_en = 1'b1;
                    if (cur.n != 0 && en_k == 2 + cur.n) begin
                        drv_val = cur.res; result = 1'b1;
                        {is_nan, is_pinf, is_ninf} = cur.fl;
                    end else begin
                        drv_val = 16'($urandom); result = 1'b0;
                        {is_nan, is_pinf, is_ninf} = 3'($urandom);
                    end
                end else begin
                    drv_en = 1'b0; result = 1'b0;
                end
            end
        end
    end

    // Compare process.
    initial begin
        bit prev_en = 1'b0, seen = 1'b0, exp_drop = 1'b0;
        int low_run = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("rst_rsp_valid", rsp_valid, 0);
                chk("rst_enable", enable, 0);
                chk("rst_rsp_data", rsp_data, 0);
                chk("rst_flags", {f_nan, f_pinf, f_ninf, f_to}, 0);
                prev_en = 1'b0; seen = 1'b0; exp_drop = 1'b0; low_run = 0;
                continue;
            end
            if (enable && !prev_en) chk("recover_gap_ok", low_run >= RC, 1);
            if (enable) low_run = 0; else low_run++;
            prev_en = enable;
            if (drv_en) chk("bus_contention", io_bus, drv_val);
            if (enable && en_k == 1) chk("drive_operand", io_bus, cur.op);
            if (req_valid && req_ready) accq.push_back(cyc);
            if (exp_drop) begin
                chk("rsp_valid_drop", rsp_valid, 0);
                exp_drop = 1'b0;
            end
            if (rsp_valid) begin
                if (expq.size() == 0 || accq.size() == 0) begin
                    chk("spurious_rsp", 1, 0);
                end else begin
                    e = expq[0];
                    chk("rsp_data", rsp_data, e.data);
                    chk("rsp_flags", {f_nan, f_pinf, f_ninf, f_to}, e.fl);
                    chk("resp_req_ready", req_ready, 0);
                    chk("resp_enable", enable, 0);
                    if (!seen) chk("latency", cyc - accq[0], e.lat);
                    seen = 1'b1;
                    if (rsp_ready) begin
                        void'(expq.pop_front());
                        void'(accq.pop_front());
                        seen = 1'b0;
                        exp_drop = 1'b1;
                    end
                end
            end
        end
    end

    task automatic wait_accept(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (req_ready) begin ok = 1'b1; break; end
        end
        if (!ok) chk("accept_bound", 0, 1);
    endtask

    task automatic run_txn(input logic [15:0] op, input int n, input logic [15:0] res,
                           input logic [2:0] fl, input int hold, input bit cold,
                           output logic [15:0] got_d, output logic [3:0] got_f, output int got_lat);
        txn_t t;
        bit ok;
        int acc;
        t = '{op: op, n: n, res: res, fl: fl};
        got_d = '0; got_f = '0; got_lat = -1;
        @(posedge clk); #1;
        req_valid = 1'b1; req_data = op; rsp_ready = 1'b0;
        wait_accept(ok);
        if (!ok) begin req_valid = 1'b0; return; end
        acc = cyc;
        txq.push_back(t);
        expq.push_back(model(t, cold));
        @(posedge clk); #1;
        req_data = 16'($urandom);      // stays valid with junk while busy; must be ignored
        ok = 1'b0;
        for (int k = 0; k < TO + 40; k++) begin
            @(negedge clk);
            if (rsp_valid) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            chk("rsp_bound", 0, 1);
            req_valid = 1'b0;
            return;
        end
        got_lat = cyc - acc;
        got_d = rsp_data;
        got_f = {f_nan, f_pinf, f_ninf, f_to};
        repeat (hold) @(posedge clk);
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        req_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        logic [15:0] d;
        logic [3:0]  f;
        int          lat;
        bit          ok;
        n_tests = 0; n_fail = 0; cyc = 0;
        rst = 1'b1; req_valid = 1'b0; req_data = '0; rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", req_ready, 1);
        rst = 1'b0;

        // First request after reset passes through RECOVER first.
        run_txn(16'hBC00, 1, 16'hFE00, 3'b100, 0, 1'b1, d, f, lat);
        chk("nan_data", d, 16'hFE00);
        chk("nan_flags", f, 4'b1000);
        chk("cold_latency", lat, 6);

        run_txn(16'h4400, 12, 16'h4000, 3'b000, 0, 1'b0, d, f, lat);
        chk("sqrt4_data", d, 16'h4000);
        chk("sqrt4_flags", f, 4'b0000);
        chk("sqrt4_latency", lat, 15);

        run_txn(16'h7C00, 5, 16'h7C00, 3'b010, 0, 1'b0, d, f, lat);
        chk("pinf_flags", f, 4'b0100);

        run_txn(16'h1234, 0, 16'h0000, 3'b000, 0, 1'b0, d, f, lat);
        chk("timeout_data", d, 16'hFE00);
        chk("timeout_flags", f, 4'b0001);
        chk("timeout_latency", lat, 3 + TO);

        run_txn(16'h3C00, TO, 16'h3C00, 3'b001, 0, 1'b0, d, f, lat);
        chk("edge_result_wins", f, 4'b0010);
        chk("edge_latency", lat, 3 + TO);

        run_txn(16'h4200, 7, 16'h3EED, 3'b000, 5, 1'b0, d, f, lat);
        chk("hold_data", d, 16'h3EED);

        // Reset in the middle of WAIT discards the transaction.
        @(posedge clk); #1;
        req_valid = 1'b1; req_data = 16'h4400;
        wait_accept(ok);
        txq.push_back('{op: 16'h4400, n: 0, res: 16'h0, fl: 3'b0});
        repeat (6) @(posedge clk);
        #1;
        chk("pre_rst_enable", enable, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_enable", enable, 0);
        chk("async_rst_rsp_valid", rsp_valid, 0);
        txq.delete(); expq.delete(); accq.delete();
        req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        run_txn(16'h4400, 12, 16'h4000, 3'b000, 0, 1'b1, d, f, lat);
        chk("post_rst_data", d, 16'h4000);
        chk("post_rst_latency", lat, 15 + RC);

        for (int i = 0; i < 40; i++) begin
            run_txn(16'($urandom), int'($urandom_range(0, TO + 3)), 16'($urandom),
                    3'($urandom_range(0, 7)), int'($urandom_range(0, 4)), 1'b0, d, f, lat);
        end

        repeat (5) @(posedge clk);
        chk("all_rsp_consumed", expq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
